// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes and FSM states.
// Also used by the decode/control unit.
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'b0000;
  localparam logic [3:0] MDU_MULT  = 4'b0001;
  localparam logic [3:0] MDU_MULTU = 4'b0010;
  localparam logic [3:0] MDU_DIV   = 4'b0011;
  localparam logic [3:0] MDU_DIVU  = 4'b0100;
  localparam logic [3:0] MDU_MTHI  = 4'b0101;
  localparam logic [3:0] MDU_MTLO  = 4'b0110;
  localparam logic [3:0] MDU_MADD  = 4'b0111;
  localparam logic [3:0] MDU_MADDU = 4'b1000;
  localparam logic [3:0] MDU_MSUB  = 4'b1001;
  localparam logic [3:0] MDU_MSUBU = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/mdu_iter_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nx,
  output logic [WIDTH-1:0] quo_nx
);

  logic [WIDTH:0] shifted;
  logic           fits;

  // Compare explicitly so a zero divisor (remainder not bounded) still
  // yields an all-ones quotient and the dividend as remainder.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    fits    = (shifted >= {1'b0, divisor});
    if (fits) begin
      rem_nx = shifted[WIDTH-1:0] - divisor;
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = shifted[WIDTH-1:0];
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit owning HI/LO. Define MDU_MADD_EN to
// enable MADD/MADDU/MSUB/MSUBU accumulate ops; otherwise they act as NOP.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int DIV_CYCLES = WIDTH + 1;
  localparam int CNT_MAX    = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CW         = $clog2(CNT_MAX);

  // Handshake: a request is start=1 with op/a/b valid; it is taken on the
  // rising edge where busy=0 (busy acts as not-ready). While busy=1 start
  // is ignored and must be held. done pulses for one cycle after HI/LO
  // are written by a multi-cycle op; busy is already low in that cycle.

  state_t                 state, state_nx;
  logic [3:0]             op_q;
  logic [WIDTH-1:0]       opa, opb, rem;
  logic [CW-1:0]          count;
  logic                   neg_q, neg_r;

  logic                   mul_req, div_req, div_signed, mul_signed;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [2*WIDTH-1:0]     ext_a, ext_b, product, mul_result;
  logic [WIDTH-1:0]       rem_nx, quo_nx;

  assign busy = (state != S_IDLE);

  always_comb begin
    mul_req = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    mul_req = mul_req || (op == MDU_MADD) || (op == MDU_MADDU) ||
              (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    div_req    = (op == MDU_DIV) || (op == MDU_DIVU);
    div_signed = (op == MDU_DIV);
    a_mag      = (div_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag      = (div_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
  end

  // Product and optional accumulate use the latched operands and the
  // HI/LO value present at completion.
  always_comb begin
    mul_signed = (op_q == MDU_MULT);
`ifdef MDU_MADD_EN
    mul_signed = mul_signed || (op_q == MDU_MADD) || (op_q == MDU_MSUB);
`endif
    ext_a      = mul_signed ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
    ext_b      = mul_signed ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
    product    = ext_a * ext_b;
    mul_result = product;
`ifdef MDU_MADD_EN
    if ((op_q == MDU_MADD) || (op_q == MDU_MADDU))
      mul_result = {hi, lo} + product;
    else if ((op_q == MDU_MSUB) || (op_q == MDU_MSUBU))
      mul_result = {hi, lo} - product;
`endif
  end

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (rem),
    .quo     (opa),
    .divisor (opb),
    .rem_nx  (rem_nx),
    .quo_nx  (quo_nx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start && mul_req)      state_nx = S_MUL;
        else if (start && div_req) state_nx = S_DIV;
      end
      S_MUL:   if (count == '0) state_nx = S_IDLE;
      S_DIV:   if (count == '0) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= MDU_NOP;
      opa   <= '0;
      opb   <= '0;
      rem   <= '0;
      count <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && mul_req) begin
            op_q  <= op;
            opa   <= a;
            opb   <= b;
            count <= CW'(MUL_CYCLES - 1);
          end else if (start && div_req) begin
            op_q  <= op;
            opa   <= a_mag;
            opb   <= b_mag;
            rem   <= '0;
            neg_q <= div_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r <= div_signed && a[WIDTH-1];
            count <= CW'(WIDTH - 1);
          end else if (start && (op == MDU_MTHI)) begin
            hi <= a;
          end else if (start && (op == MDU_MTLO)) begin
            lo <= a;
          end
        end
        S_MUL: begin
          if (count == '0) begin
            {hi, lo} <= mul_result;
            done     <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        S_DIV: begin
          rem <= rem_nx;
          opa <= quo_nx;
          if (count != '0) count <= count - 1'b1;
        end
        S_FIX: begin
          lo   <= neg_q ? (~opa + 1'b1) : opa;
          hi   <= neg_r ? (~rem + 1'b1) : rem;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed HI/LO values.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W     = 32;
  localparam int N_MUL = 5;
  localparam int N_DIV = W + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = MDU_NOP;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mdu_iter dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0;
  logic [3:0]   m_op = MDU_NOP;
  int           m_left = 0;
  logic         m_done = 1'b0;

  function automatic logic [2*W-1:0] model_result(input logic [3:0] k, input logic [W-1:0] x,
                                                  input logic [W-1:0] y, input logic [W-1:0] h,
                                                  input logic [W-1:0] l);
    longint       sp, q, r;
    logic [2*W-1:0] up, acc;
    sp  = longint'($signed(x)) * longint'($signed(y));
    up  = {32'b0, x} * {32'b0, y};
    acc = {h, l};
    case (k)
      MDU_MULT:  return 64'(sp);
      MDU_MULTU: return up;
      MDU_MADD:  return acc + 64'(sp);
      MDU_MADDU: return acc + up;
      MDU_MSUB:  return acc - 64'(sp);
      MDU_MSUBU: return acc - up;
      MDU_DIV: begin
        if (y == '0) return {x, (x[W-1] ? 32'h1 : 32'hFFFF_FFFF)};
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        return {r[31:0], q[31:0]};
      end
      MDU_DIVU: begin
        if (y == '0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return acc;
    endcase
  endfunction

  function automatic bit is_mul(input logic [3:0] k);
`ifdef MDU_MADD_EN
    return (k == MDU_MULT) || (k == MDU_MULTU) || (k == MDU_MADD) || (k == MDU_MADDU) ||
           (k == MDU_MSUB) || (k == MDU_MSUBU);
`else
    return (k == MDU_MULT) || (k == MDU_MULTU);
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = model_result(m_op, m_a, m_b, m_hi, m_lo);
          m_done = 1'b1;
        end
      end else if (start) begin
        if (is_mul(op) || op == MDU_DIV || op == MDU_DIVU) begin
          m_op = op; m_a = a; m_b = b;
          m_left = is_mul(op) ? N_MUL : N_DIV;
        end else if (op == MDU_MTHI) m_hi = a;
        else if (op == MDU_MTLO) m_lo = a;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cyc busy", 32'(busy), 32'(m_left > 0));
      check("cyc done", 32'(done), 32'(m_done));
      check("cyc hi", hi, m_hi);
      check("cyc lo", lo, m_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NOP;
  endtask

  task automatic wait_idle(input string name, input int n_exp);
    int cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check({name, " busy_len"}, 32'(cnt), 32'(n_exp));
    check({name, " done"}, 32'(done), 32'h1);
  endtask

  typedef struct {
    logic [3:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
  } vec_t;

  vec_t vecs[6] = '{
    '{MDU_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF},
    '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{MDU_DIV,   32'h0000_0007, 32'hFFFF_FFFE},
    '{MDU_DIV,   32'h0000_0000, 32'hFFFF_FFFB},
    '{MDU_DIV,   32'hFFFF_FFF0, 32'h0000_0000},
    '{MDU_MULT,  32'h8000_0000, 32'h8000_0000}
  };

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst busy", 32'(busy), 32'h0);
    check("rst done", 32'(done), 32'h0);
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    issue(MDU_MULT, 32'hFFFF_FFFE, 32'h3);
    wait_idle("mult", N_MUL);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFFA);

    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'h3);
    wait_idle("multu", N_MUL);
    check("multu hi", hi, 32'h0000_0002);
    check("multu lo", lo, 32'hFFFF_FFFA);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'h2);
    wait_idle("div", N_DIV);
    check("div lo", lo, 32'hFFFF_FFFD);
    check("div hi", hi, 32'hFFFF_FFFF);

    issue(MDU_DIVU, 32'h7, 32'h2);
    wait_idle("divu", N_DIV);
    check("divu lo", lo, 32'h3);
    check("divu hi", hi, 32'h1);

    issue(MDU_DIVU, 32'h1234_5678, 32'h0);
    wait_idle("divu0", N_DIV);
    check("divu0 lo", lo, 32'hFFFF_FFFF);
    check("divu0 hi", hi, 32'h1234_5678);

    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("divmin", N_DIV);
    check("divmin lo", lo, 32'h8000_0000);
    check("divmin hi", hi, 32'h0);

    @(posedge clk); #1;
    start = 1'b1; op = MDU_MTHI; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    op = MDU_MTLO; a = 32'h1;
    @(posedge clk); #1;
    start = 1'b0; op = MDU_NOP;
    @(negedge clk);
    check("mt hi", hi, 32'hDEAD_BEEF);
    check("mt lo", lo, 32'h1);
    check("mt busy", 32'(busy), 32'h0);

    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].x, vecs[i].y);
      wait_idle("vec", is_mul(vecs[i].o) ? N_MUL : N_DIV);
    end

    // start held high: re-accepted in the cycle busy drops
    @(posedge clk); #1;
    start = 1'b1; op = MDU_MULTU; a = 32'h3; b = 32'h5;
    repeat (12) @(posedge clk);
    #1 start = 1'b0; op = MDU_NOP;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("b2b lo", lo, 32'hF);
    check("b2b hi", hi, 32'h0);

    // MULT during an in-flight DIV is dropped
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 start = 1'b1; op = MDU_MULT; a = 32'h10; b = 32'h10;
    @(posedge clk); #1 start = 1'b0; op = MDU_NOP;
    wait_idle("divbusy", N_DIV - 10);
    check("divbusy lo", lo, 32'd14);
    check("divbusy hi", hi, 32'd2);

    // reset in the middle of a second DIV
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'h2);
    repeat (19) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'h0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    check("abort done", 32'(done), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (40) @(posedge clk);

    issue(MDU_MTHI, 32'h0, 32'h0);
    issue(MDU_MTLO, 32'hFFFF_FFFF, 32'h0);
    issue(MDU_MADDU, 32'h1, 32'h1);
`ifdef MDU_MADD_EN
    wait_idle("maddu", N_MUL);
    check("maddu hi", hi, 32'h1);
    check("maddu lo", lo, 32'h0);
`else
    @(negedge clk);
    check("maddu off busy", 32'(busy), 32'h0);
    check("maddu off hi", hi, 32'h0);
    check("maddu off lo", lo, 32'hFFFF_FFFF);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
